// File: rtl/drive_actuator_ramp.sv
// drive_actuator_ramp: ramps the motor speed code toward the commanded
// (steering-limited) target, brakes quickly on a stop command, produces a
// 15-slot motor PWM, and only passes steering through at low speed.
// Optional blinkers are enabled by defining DRIVE_ACTUATOR_BLINK_EN.
module drive_actuator_ramp #(
  parameter int unsigned RAMP_TICKS   = 4,
  parameter int unsigned BRAKE_TICKS  = 1,
  parameter int unsigned TURN_MAX_SPD = 2,
  parameter int unsigned BLINK_TICKS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] engine_tgt,
  input  logic [1:0] handle,
  output logic [3:0] speed_cur,
  output logic [1:0] steer,
  output logic       pwm_out,
  output logic [2:0] state,
  output logic       at_target,
  output logic       blink_l,
  output logic       blink_r
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ACCEL  = 3'b001,
    ST_CRUISE = 3'b010,
    ST_DECEL  = 3'b011,
    ST_BRAKE  = 3'b100
  } state_t;

  localparam int unsigned PER_MAX = (RAMP_TICKS > BRAKE_TICKS) ? RAMP_TICKS : BRAKE_TICKS;
  localparam int unsigned TW      = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;
  localparam logic [TW-1:0] RAMP_LAST  = TW'(RAMP_TICKS - 1);
  localparam logic [TW-1:0] BRAKE_LAST = TW'(BRAKE_TICKS - 1);
  localparam logic [3:0]    TURN_MAX   = 4'(TURN_MAX_SPD);
  localparam logic [3:0]    PWM_LAST   = 4'd14;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    speed_q, speed_d;
  logic [1:0]    steer_q, steer_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic          pwm_q, pwm_d;
  logic [1:0]    handle_n;
  logic [3:0]    eff_tgt;

  // Sanitised handle and the speed target after the turning limit.
  always_comb begin
    handle_n = (handle == 2'b11) ? 2'b00 : handle;
    eff_tgt  = engine_tgt;
    if (handle_n != 2'b00 && engine_tgt > TURN_MAX) begin
      eff_tgt = TURN_MAX;
    end
  end

  // Next state from the registered speed and the live target.
  always_comb begin
    state_d = state_q;
    if (eff_tgt == 4'd0 && speed_q != 4'd0) begin
      state_d = ST_BRAKE;
    end else if (speed_q < eff_tgt) begin
      state_d = ST_ACCEL;
    end else if (speed_q > eff_tgt) begin
      state_d = ST_DECEL;
    end else if (speed_q != 4'd0) begin
      state_d = ST_CRUISE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Step timer and speed stepping; a state change restarts the timer and
  // suppresses the step so a reversed ramp always starts with a full period.
  always_comb begin
    tick_d  = tick_q;
    speed_d = speed_q;
    if (state_d != state_q) begin
      tick_d = '0;
    end else begin
      case (state_q)
        ST_ACCEL: begin
          if (tick_q == RAMP_LAST) begin
            tick_d = '0;
            if (speed_q != 4'hF) speed_d = speed_q + 4'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DECEL: begin
          if (tick_q == RAMP_LAST) begin
            tick_d = '0;
            if (speed_q != 4'd0) speed_d = speed_q - 4'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_BRAKE: begin
          if (tick_q == BRAKE_LAST) begin
            tick_d = '0;
            if (speed_q != 4'd0) speed_d = speed_q - 4'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: tick_d = '0;
      endcase
    end
  end

  // Steering gate and PWM comparator.
  always_comb begin
    steer_d   = (speed_q <= TURN_MAX) ? handle_n : 2'b00;
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 4'd0 : pwm_cnt_q + 4'd1;
    pwm_d     = (pwm_cnt_q < speed_q);
  end

  // Core registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      speed_q   <= '0;
      steer_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      speed_q   <= speed_d;
      steer_q   <= steer_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign speed_cur = speed_q;
  assign steer     = steer_q;
  assign pwm_out   = pwm_q;
  assign state     = state_q;
  assign at_target = (speed_q == eff_tgt);

`ifdef DRIVE_ACTUATOR_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_l_q, blink_l_d, blink_r_q, blink_r_d;

  // Blinker toggling; a direct left/right swap restarts the phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_l_d   = blink_l_q;
    blink_r_d   = blink_r_q;
    if (steer_q == 2'b00 || (steer_d != steer_q && steer_d != 2'b00)) begin
      blink_cnt_d = '0;
      blink_l_d   = 1'b0;
      blink_r_d   = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      if (steer_q == 2'b01) begin
        blink_l_d = ~blink_l_q;
        blink_r_d = 1'b0;
      end else begin
        blink_r_d = ~blink_r_q;
        blink_l_d = 1'b0;
      end
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Blinker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_l_q   <= 1'b0;
      blink_r_q   <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_l_q   <= blink_l_d;
      blink_r_q   <= blink_r_d;
    end
  end

  assign blink_l = blink_l_q;
  assign blink_r = blink_r_q;
`else
  localparam int unsigned UNUSED_BLINK_TICKS = BLINK_TICKS;
  assign blink_l = 1'b0;
  assign blink_r = 1'b0;
`endif

endmodule

// File: tb/tb_drive_actuator_ramp.sv
// Scoreboard bench for drive_actuator_ramp: each scenario pushes the
// expected registered outputs per cycle and then consumes them edge by edge.
module tb_drive_actuator_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] engine_tgt;
  logic [1:0] handle;
  logic [3:0] speed_cur;
  logic [1:0] steer;
  logic       pwm_out;
  logic [2:0] state;
  logic       at_target;
  logic       blink_l;
  logic       blink_r;

  always #5 clk = ~clk;

  drive_actuator_ramp #(
    .RAMP_TICKS  (4),
    .BRAKE_TICKS (1),
    .TURN_MAX_SPD(2),
    .BLINK_TICKS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .engine_tgt(engine_tgt),
    .handle    (handle),
    .speed_cur (speed_cur),
    .steer     (steer),
    .pwm_out   (pwm_out),
    .state     (state),
    .at_target (at_target),
    .blink_l   (blink_l),
    .blink_r   (blink_r)
  );

`ifdef DRIVE_ACTUATOR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_ACCEL = 3'd1, S_CRUISE = 3'd2,
                         S_DECEL = 3'd3, S_BRAKE = 3'd4;

  // observation layout: {state, speed, steer, pwm, at_target, blink_l, blink_r}
  typedef logic [12:0] obs_t;
  typedef struct {
    obs_t val;
    obs_t msk;
  } exp_t;

  function automatic obs_t pk(logic [2:0] st, logic [3:0] sp, logic [1:0] sr,
                              logic p, logic a, logic l, logic r);
    return {st, sp, sr, p, a, l, r};
  endfunction

  function automatic obs_t observe();
    return pk(state, speed_cur, steer, pwm_out, at_target, blink_l, blink_r);
  endfunction

  localparam obs_t M_ALL = '1;
  localparam obs_t M_SS  = {3'h7, 4'hF, 2'h3, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam obs_t M_PWM = {3'h0, 4'h0, 2'h0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam obs_t M_BL  = {3'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b1, 1'b1};

  exp_t sbq[$];
  int   pwm_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(obs_t v, obs_t m);
    exp_t e;
    e.val = v;
    e.msk = m;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    int   n;
    reset = 1'b1; engine_tgt = 4'd0; handle = 2'b00;
    for (int i = 0; i < 3; i++) push(pk(S_IDLE, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_ALL);
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL reset c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_accel();
    exp_t e;
    obs_t o;
    int   n, sp;
    reset = 1'b0; engine_tgt = 4'd3; handle = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      sp = ((i - 1) / 4 > 3) ? 3 : (i - 1) / 4;
      push(pk((i <= 13) ? S_ACCEL : S_CRUISE, 4'(sp), 2'b00, 1'b0, sp == 3, 1'b0, 1'b0), M_SS);
    end
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL accel c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_brake();
    exp_t e;
    obs_t o;
    int   n, sp;
    engine_tgt = 4'd12;
    repeat (60) cyc();
    push(pk(S_CRUISE, 4'd12, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS);
    cyc();
    engine_tgt = 4'd0;
    for (int i = 1; i <= 30; i++) begin
      sp = (i <= 13) ? 13 - i : 0;
      push(pk((i <= 13) ? S_BRAKE : S_IDLE, 4'(sp), 2'b00, 1'b0, sp == 0, 1'b0, 1'b0),
           (i >= 14) ? (M_SS | M_PWM) : M_SS);
    end
    // first entry belongs to the edge already taken above
    e = sbq.pop_front(); o = observe(); checks++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL brake_pre: got %h expected %h mask %h", o, e.val, e.msk);
    end
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL brake c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_turn_decel();
    exp_t e;
    obs_t o;
    int   n, sp, prev;
    engine_tgt = 4'd8; handle = 2'b00;
    repeat (45) cyc();
    push(pk(S_CRUISE, 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS);
    prev = 8;
    for (int i = 1; i <= 30; i++) begin
      sp = 8 - (i - 1) / 4;
      if (sp < 2) sp = 2;
      push(pk((i <= 25) ? S_DECEL : S_CRUISE, 4'(sp), (prev <= 2) ? 2'b01 : 2'b00,
              1'b0, sp == 2, 1'b0, 1'b0), M_SS);
      prev = sp;
    end
    n = 0;
    while (sbq.size() > 0) begin
      if (n == 1) begin
        engine_tgt = 4'd8; handle = 2'b01;
      end
      cyc(); n++;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL turn_decel c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_pwm();
    exp_t e;
    obs_t o;
    int   n, cnt, want;
    handle = 2'b00; engine_tgt = 4'd5;
    repeat (30) cyc();
    push(pk(S_CRUISE, 4'd5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS);
    pwm_q.push_back(5);
    pwm_q.push_back(5);
    cyc();
    e = sbq.pop_front(); o = observe(); checks++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL pwm_hold5: got %h expected %h mask %h", o, e.val, e.msk);
    end
    while (pwm_q.size() > 0) begin
      cnt = 0;
      repeat (15) begin
        cyc();
        cnt += int'(pwm_out);
      end
      want = pwm_q.pop_front(); checks++;
      if (cnt !== want) begin
        errors++;
        $display("FAIL pwm_window: got %0d high cycles expected %0d", cnt, want);
      end
      cyc();
    end
    engine_tgt = 4'd15;
    repeat (50) cyc();
    for (int i = 0; i < 30; i++)
      push(pk(S_CRUISE, 4'd15, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0), M_SS | M_PWM);
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL pwm_full c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    int   n;
    reset = 1'b1;
    push(pk(S_IDLE, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    for (int i = 1; i <= 26; i++)
      push(pk(S_ACCEL, 4'((i - 1) / 4), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), M_SS);
    push(pk(S_IDLE, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    for (int i = 1; i <= 9; i++)
      push(pk(S_ACCEL, 4'((i - 1) / 4), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), M_SS);
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      if (n == 1)  begin reset = 1'b0; engine_tgt = 4'd10; end
      if (n == 27) begin reset = 1'b1; end
      if (n == 28) begin reset = 1'b0; engine_tgt = 4'd6; end
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL reset_mid c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    obs_t o;
    int   n;
    logic ph;
    engine_tgt = 4'd1; handle = 2'b00;
    repeat (30) cyc();
    push(pk(S_CRUISE, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS | M_BL);
    for (int i = 1; i <= 40; i++) begin
      ph = BLINK && (((i - 1) / 8) % 2 == 1);
      push(pk(S_CRUISE, 4'd1, 2'b10, 1'b0, 1'b1, 1'b0, ph), M_SS | M_BL);
    end
    push(pk(S_CRUISE, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS);
    for (int i = 2; i <= 12; i++)
      push(pk(S_CRUISE, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS | M_BL);
    for (int i = 1; i <= 6; i++)
      push(pk(S_CRUISE, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), M_SS | M_BL);
    for (int i = 1; i <= 20; i++) begin
      ph = BLINK && (((i - 1) / 8) % 2 == 1);
      push(pk(S_CRUISE, 4'd1, 2'b01, 1'b0, 1'b1, ph, 1'b0), M_SS | M_BL);
    end
    n = 0;
    while (sbq.size() > 0) begin
      cyc(); n++;
      if (n == 1)  handle = 2'b10;
      if (n == 41) handle = 2'b00;
      if (n == 53) handle = 2'b11;
      if (n == 59) handle = 2'b01;
      e = sbq.pop_front(); o = observe(); checks++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL blink c%0d: got %h expected %h mask %h", n, o, e.val, e.msk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_brake();
    test_turn_decel();
    test_pwm();
    test_reset_mid();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
